// File: rtl/usb_pkg.sv
// Shared sizing constants for the USB data-path buffers.
package usb_pkg;

    localparam int unsigned BUFFER_DEPTH = 64;
    localparam int unsigned ADDR_W       = 6;
    localparam int unsigned OCC_W        = 7;

endpackage

// File: rtl/buffer_ptr.sv
// Wrap-bit circular-buffer pointer: increment enable, synchronous clear, async reset.
module buffer_ptr
    import usb_pkg::*;
(
    input  logic             clk,
    input  logic             n_rst,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [OCC_W-1:0] ptr_o
);

    logic [OCC_W-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = ptr_q + OCC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/rx_data_buffer.sv
// 64-entry byte FIFO shared between usb_rx/host writers and host/TX readers.
module rx_data_buffer
    import usb_pkg::*;
(
    input  logic             clk,
    input  logic             n_rst,
    input  logic             store_rx_packet_data,
    input  logic [7:0]       rx_packet_data,
    input  logic             store_tx_data,
    input  logic [7:0]       tx_data,
    input  logic             get_rx_data,
    input  logic             get_tx_packet_data,
    input  logic             flush,
    input  logic             clear,
    output logic [OCC_W-1:0] buffer_occupancy,
    output logic [7:0]       rx_data,
    output logic [7:0]       tx_packet_data,
    output logic             overrun,
    output logic             underrun
);

    localparam logic [OCC_W-1:0] FullOcc = OCC_W'(BUFFER_DEPTH);

    logic [OCC_W-1:0] wptr, rptr;
    logic [7:0]       mem_q [BUFFER_DEPTH];
    logic [7:0]       rx_data_q, tx_data_q;
    logic             overrun_q, underrun_q;

    logic       wr_req, rd_req, empty_req, full, empty;
    logic       wr_ok, rd_ok;
    logic [7:0] wr_byte, rd_byte;

    assign buffer_occupancy = wptr - rptr;
    assign full             = (buffer_occupancy == FullOcc);
    assign empty            = (buffer_occupancy == '0);

    assign wr_req    = store_rx_packet_data | store_tx_data;
    assign rd_req    = get_rx_data | get_tx_packet_data;
    assign empty_req = flush | clear;

    // Full/empty come from pre-edge occupancy; a flush/clear wins over everything.
    assign wr_ok   = wr_req & ~full & ~empty_req;
    assign rd_ok   = rd_req & ~empty & ~empty_req;
    assign wr_byte = store_rx_packet_data ? rx_packet_data : tx_data;
    assign rd_byte = mem_q[rptr[ADDR_W-1:0]];

    buffer_ptr u_wptr (
        .clk   (clk),
        .n_rst (n_rst),
        .inc_i (wr_ok),
        .clr_i (empty_req),
        .ptr_o (wptr)
    );

    buffer_ptr u_rptr (
        .clk   (clk),
        .n_rst (n_rst),
        .inc_i (rd_ok),
        .clr_i (empty_req),
        .ptr_o (rptr)
    );

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wptr[ADDR_W-1:0]] <= wr_byte;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rx_data_q  <= 8'h00;
            tx_data_q  <= 8'h00;
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            overrun_q  <= wr_req & full & ~empty_req;
            underrun_q <= rd_req & empty & ~empty_req;
            if (rd_ok && get_rx_data) begin
                rx_data_q <= rd_byte;
            end
            if (rd_ok && get_tx_packet_data) begin
                tx_data_q <= rd_byte;
            end
        end
    end

    assign rx_data        = rx_data_q;
    assign tx_packet_data = tx_data_q;
    assign overrun        = overrun_q;
    assign underrun       = underrun_q;

endmodule
